// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared definitions for the keypad scanner. Holds the FSM
//               state encoding and the helpers used to step the row index
//               and to turn (row, column) into a key code.
// Contents    : state_e       - scanner FSM states
//               c_row_first   - index of the row driven out of reset
//               next_row()    - row index advance with wrap
//               key_code()    - row_index*cols + col_index
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_PRESSED = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int c_row_first = 0;

  // Row following idx; the last row wraps back to the first.
  function automatic int next_row(input int idx, input int rows);
    return (idx == rows - 1) ? c_row_first : idx + 1;
  endfunction

  function automatic int key_code(input int row_idx, input int col_idx, input int cols);
    return row_idx * cols + col_idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchroniser for a bus of independent, slowly
//               changing lines (keypad columns). Resets to all-ones, the
//               idle level of active-low inputs.
// Ports       : clk   in  - destination clock
//               rst_n in  - asynchronous active-low reset
//               d_i   in  - asynchronous input lines
//               q_o   out - synchronised lines
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Row-scanning matrix keypad controller with debounce. One
//               row is driven low at a time; after SETTLE clocks the
//               synchronised columns are sampled. A press must be seen
//               DEBOUNCE samples in a row before it is accepted, and a
//               release likewise before scanning resumes. Accepted codes are
//               offered on a valid/ready interface; a press that arrives
//               while an older code is still pending sets a sticky overflow.
// Ports       : clk       in  - clock, rising edge
//               rst_n     in  - asynchronous active-low reset
//               column    in  - raw active-low column lines (async)
//               row       out - one-cold active-low row drive
//               key       out - accepted key code, row*COLS + col
//               key_valid out - key holds an unconsumed code
//               key_ready in  - consumer takes key when high with key_valid
//               key_held  out - debounced key is currently down
//               overflow  out - sticky, a press was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [COLS-1:0]               column,
  output logic [ROWS-1:0]               row,
  output logic [$clog2(ROWS*COLS)-1:0]  key,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          key_held,
  output logic                          overflow
);

  localparam int c_kw = $clog2(ROWS * COLS);
  localparam int c_rw = $clog2(ROWS);
  localparam int c_cw = $clog2(COLS);
  localparam int c_sw = $clog2(SETTLE);
  localparam int c_dw = $clog2(DEBOUNCE + 1);

  // --------------------------------------------------------------------------
  // Column synchroniser
  // --------------------------------------------------------------------------
  logic [COLS-1:0] w_col_sync;

  sync2 #(
    .WIDTH (COLS)
  ) u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (column),
    .q_o   (w_col_sync)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e            state_q;
  logic [ROWS-1:0]   row_q;
  logic [c_rw-1:0]   row_idx_q;
  logic [c_sw-1:0]   settle_q;
  logic [c_dw-1:0]   deb_q;
  logic [c_kw-1:0]   cand_q;
  logic [c_kw-1:0]   key_q;
  logic              key_valid_q;
  logic              key_held_q;
  logic              overflow_q;

  // --------------------------------------------------------------------------
  // Sample decode
  // --------------------------------------------------------------------------
  logic              w_any_low;
  logic [c_cw-1:0]   w_col_idx;
  logic [c_kw-1:0]   w_code;
  logic [c_rw-1:0]   w_next_idx;
  logic              w_sample;
  logic              w_match;
  logic              w_accept;
  logic              w_release_done;
  logic              w_consume;

  always_comb begin
    w_any_low = ~&w_col_sync;

    // Walk from the top so the lowest low column wins.
    w_col_idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!w_col_sync[i]) begin
        w_col_idx = c_cw'(i);
      end
    end

    w_code     = c_kw'(key_code(int'(row_idx_q), int'(w_col_idx), COLS));
    w_next_idx = c_rw'(next_row(int'(row_idx_q), ROWS));

    // The settle counter free-runs modulo SETTLE in every state, so the
    // same tick drives the scan sample and each debounce resample.
    w_sample = (settle_q == c_sw'(SETTLE - 1));
    w_match  = w_any_low && (w_code == cand_q);

    // The detecting sample in SCAN counts as the first of DEBOUNCE matches;
    // likewise the first all-high sample in PRESSED for the release.
    w_accept = w_sample &&
               (((state_q == ST_SCAN) && w_any_low && (DEBOUNCE == 1)) ||
                ((state_q == ST_CONFIRM) && w_match &&
                 (deb_q == c_dw'(DEBOUNCE - 1))));

    w_release_done = w_sample && !w_any_low &&
                     (((state_q == ST_PRESSED) && (DEBOUNCE == 1)) ||
                      ((state_q == ST_RELEASE) &&
                       (deb_q == c_dw'(DEBOUNCE - 1))));

    w_consume = key_valid_q && key_ready;
  end

  // --------------------------------------------------------------------------
  // Scanner FSM and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      row_q       <= {{(ROWS - 1){1'b1}}, 1'b0};
      row_idx_q   <= c_rw'(c_row_first);
      settle_q    <= '0;
      deb_q       <= '0;
      cand_q      <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      settle_q <= w_sample ? '0 : settle_q + 1'b1;

      if (w_consume) begin
        key_valid_q <= 1'b0;
      end

      // A pending, unconsumed code is never overwritten; the new press is
      // dropped and flagged instead.
      if (w_accept) begin
        if (!key_valid_q || w_consume) begin
          key_q       <= w_code;
          key_valid_q <= 1'b1;
        end else begin
          overflow_q  <= 1'b1;
        end
      end

      case (state_q)
        ST_SCAN: begin
          if (w_sample) begin
            if (!w_any_low) begin
              row_q     <= {row_q[ROWS-2:0], row_q[ROWS-1]};
              row_idx_q <= w_next_idx;
            end else begin
              cand_q <= w_code;
              deb_q  <= c_dw'(1);
              if (w_accept) begin
                state_q    <= ST_PRESSED;
                key_held_q <= 1'b1;
              end else begin
                state_q    <= ST_CONFIRM;
              end
            end
          end
        end

        ST_CONFIRM: begin
          if (w_sample) begin
            if (!w_match) begin
              state_q <= ST_SCAN;
            end else if (w_accept) begin
              state_q    <= ST_PRESSED;
              key_held_q <= 1'b1;
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end
        end

        ST_PRESSED: begin
          if (w_sample && !w_any_low) begin
            if (w_release_done) begin
              key_held_q <= 1'b0;
              row_q      <= {row_q[ROWS-2:0], row_q[ROWS-1]};
              row_idx_q  <= w_next_idx;
              state_q    <= ST_SCAN;
            end else begin
              deb_q   <= c_dw'(1);
              state_q <= ST_RELEASE;
            end
          end
        end

        ST_RELEASE: begin
          if (w_sample) begin
            if (w_any_low) begin
              state_q <= ST_PRESSED;
            end else if (w_release_done) begin
              key_held_q <= 1'b0;
              row_q      <= {row_q[ROWS-2:0], row_q[ROWS-1]};
              row_idx_q  <= w_next_idx;
              state_q    <= ST_SCAN;
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

  assign row       = row_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire
